// File: rtl/alu_result_queue.sv
// alu_result_queue: show-ahead FIFO of ALU results carrying zero, negative and divide-by-zero flags
module alu_result_queue #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_op,
  input  logic [DATA_WIDTH-1:0]   in_f,
  input  logic [DATA_WIDTH-1:0]   in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_zero,
  output logic                    out_neg,
  output logic                    out_dz,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [2:0] mem_flags [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop, dz;
  logic [DATA_WIDTH-1:0] wdata;
  always_comb begin
    in_ready = count != FULL;
    out_valid = count != '0;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    dz = in_op == 3'b011 && in_b == '0;
    wdata = dz ? '0 : in_f;
    out_data = out_valid ? mem_data[rd_ptr] : '0;
    out_dz = out_valid && mem_flags[rd_ptr][2];
    out_neg = out_valid && mem_flags[rd_ptr][1];
    out_zero = out_valid && mem_flags[rd_ptr][0];
  end
  // storage is deliberately unreset; empty-state output gating hides stale data
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= wdata;
      mem_flags[wr_ptr] <= {dz, wdata[DATA_WIDTH-1], wdata == '0};
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed checks of the ALU result queue at DATA_WIDTH=16, DEPTH=4
module tb_alu_result_queue;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, out_zero, out_neg, out_dz;
  logic [2:0] in_op = '0;
  logic [15:0] in_f = '0, in_b = '0, out_data;
  logic [2:0] count;
  int total = 0, bad = 0;

  alu_result_queue #(.DATA_WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_f(in_f), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_zero(out_zero),
    .out_neg(out_neg), .out_dz(out_dz), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] f, input logic [2:0] op, input logic [15:0] b);
    in_valid = 1; in_f = f; in_op = op; in_b = b;
    tick;
    in_valid = 0; in_f = 16'hDEAD; in_op = 3'b011; in_b = 0;
  endtask

  task automatic test_reset;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if ({out_data, out_zero, out_neg, out_dz} !== 19'd0) begin bad++; $display("FAIL rst_outputs got=%h/%b%b%b exp=0", out_data, out_zero, out_neg, out_dz); end
    tick; tick;
    rst_n = 1;
    tick;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL post_rst got v=%b r=%b c=%0d exp v=0 r=1 c=0", out_valid, in_ready, count); end
  endtask

  task automatic test_basic;
    push(16'h0005, 3'b000, 16'h0000);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 16'h0005) begin bad++; $display("FAIL basic_data got=%h exp=0005", out_data); end
    total++; if ({out_zero, out_neg, out_dz} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b exp=000", {out_zero, out_neg, out_dz}); end
    total++; if (count !== 3'd1) begin bad++; $display("FAIL basic_count got=%0d exp=1", count); end
    out_ready = 1; tick; out_ready = 0;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || out_data !== 16'h0) begin bad++; $display("FAIL basic_pop got v=%b c=%0d d=%h exp v=0 c=0 d=0000", out_valid, count, out_data); end
  endtask

  task automatic test_flags;
    push(16'h1234, 3'b011, 16'h0000);
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL dz_data got=%h exp=0000", out_data); end
    total++; if ({out_zero, out_neg, out_dz} !== 3'b101) begin bad++; $display("FAIL dz_flags got=%b exp=101", {out_zero, out_neg, out_dz}); end
    out_ready = 1;
    push(16'hFFFE, 3'b011, 16'h0005);
    total++; if (count !== 3'd1 || out_data !== 16'hFFFE) begin bad++; $display("FAIL div_ok got c=%0d d=%h exp c=1 d=fffe", count, out_data); end
    total++; if ({out_zero, out_neg, out_dz} !== 3'b010) begin bad++; $display("FAIL div_ok_flags got=%b exp=010", {out_zero, out_neg, out_dz}); end
    push(16'h0000, 3'b001, 16'h0000);
    total++; if (out_data !== 16'h0000 || {out_zero, out_neg, out_dz} !== 3'b100) begin bad++; $display("FAIL zero_nodiv got d=%h f=%b exp d=0000 f=100", out_data, {out_zero, out_neg, out_dz}); end
    tick; out_ready = 0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flags_drain got c=%0d v=%b exp c=0 v=0", count, out_valid); end
  endtask

  task automatic test_full;
    for (int k = 1; k <= 4; k++) push(16'(k), 3'b000, 16'h0);
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full got c=%0d r=%b exp c=4 r=0", count, in_ready); end
    push(16'h0005, 3'b000, 16'h0);
    total++; if (count !== 3'd4 || out_data !== 16'h0001) begin bad++; $display("FAIL full_ignore got c=%0d d=%h exp c=4 d=0001", count, out_data); end
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (out_data !== 16'(k)) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", k, out_data, 16'(k)); end
      tick;
    end
    out_ready = 0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got c=%0d v=%b exp c=0 v=0", count, out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_q [$];
    logic [15:0] e;
    push(16'h0101, 3'b000, 16'h0);
    push(16'h0102, 3'b000, 16'h0);
    exp_q = '{16'h0101, 16'h0102};
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      exp_q.push_back(16'h8000 + 16'(i));
      total++; if (out_data !== e || out_neg !== e[15] || count !== 3'd2) begin bad++; $display("FAIL b2b_%0d got d=%h n=%b c=%0d exp d=%h n=%b c=2", i, out_data, out_neg, count, e, e[15]); end
      push(16'h8000 + 16'(i), 3'b000, 16'h0);
    end
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      total++; if (out_data !== e || out_neg !== 1'b1) begin bad++; $display("FAIL b2b_tail_%0d got d=%h n=%b exp d=%h n=1", i, out_data, out_neg, e); end
      tick;
    end
    out_ready = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < 3; k++) push(16'h0030 + 16'(k), 3'b000, 16'h0);
    #3 rst_n = 0;
    #1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0) begin bad++; $display("FAIL async_rst got c=%0d v=%b r=%b d=%h exp c=0 v=0 r=1 d=0000", count, out_valid, in_ready, out_data); end
    #1 rst_n = 1;
    @(posedge clk); #1;
    push(16'h00AA, 3'b000, 16'h0);
    total++; if (out_data !== 16'h00AA || count !== 3'd1) begin bad++; $display("FAIL post_rst_push got d=%h c=%0d exp d=00aa c=1", out_data, count); end
    out_ready = 1; tick; out_ready = 0;
  endtask

  task automatic test_full_pop;
    for (int k = 1; k <= 4; k++) push(16'h0010 + 16'(k), 3'b000, 16'h0);
    out_ready = 1;
    push(16'h0099, 3'b000, 16'h0);
    total++; if (count !== 3'd3 || in_ready !== 1'b1 || out_data !== 16'h0012) begin bad++; $display("FAIL full_pop got c=%0d r=%b d=%h exp c=3 r=1 d=0012", count, in_ready, out_data); end
    for (int k = 2; k <= 4; k++) begin
      total++; if (out_data !== 16'h0010 + 16'(k)) begin bad++; $display("FAIL full_pop_drain_%0d got=%h exp=%h", k, out_data, 16'h0010 + 16'(k)); end
      tick;
    end
    total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL full_pop_empty got c=%0d v=%b exp c=0 v=0", count, out_valid); end
    out_ready = 0;
  endtask

  task automatic test_empty_pop;
    out_ready = 1; tick;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_pop got=%0d exp=0", count); end
    push(16'h0042, 3'b000, 16'h0);
    total++; if (count !== 3'd1 || out_data !== 16'h0042) begin bad++; $display("FAIL empty_push got c=%0d d=%h exp c=1 d=0042", count, out_data); end
    tick; out_ready = 0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL empty_final got=%0d exp=0", count); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_flags;
    test_full;
    test_back_to_back;
    test_async_reset;
    test_full_pop;
    test_empty_pop;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_result_queue.md
ALU_RESULT_QUEUE -- requirements
Module: alu_result_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of ALU result and operand b.
REQ-002 Parameter DEPTH, default 4: entry count; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  upstream ALU result valid this cycle.
REQ-006 in_ready  output  1  queue can accept a result this cycle.
REQ-007 in_op  input  3  ALU opcode that produced in_f (000 add … 011 div … 111 and).
REQ-008 in_f  input  DATA_WIDTH  ALU result.
REQ-009 in_b  input  DATA_WIDTH  ALU operand b, used only for divide-by-zero detection.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  downstream accepts head entry.
REQ-012 out_data  output  DATA_WIDTH  head result.
REQ-013 out_zero  output  1  head result equals zero.
REQ-014 out_neg  output  1  head result MSB set.
REQ-015 out_dz  output  1  head result came from a divide with b == 0.
REQ-016 count  output  clog2(DEPTH)+1  number of stored entries.

Function
REQ-017 Push SHALL occur on a rising edge when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count != DEPTH), with no combinational dependence on out_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 On push, dz = (in_op == 3'b011) && (in_b == 0); stored data = dz ? 0 : in_f.
REQ-021 On push, zero flag = (stored data == 0); neg flag = stored data[DATA_WIDTH-1]; all flags computed from stored data, then held with the entry.
REQ-022 Head output is show-ahead: out_data/out_zero/out_neg/out_dz SHALL reflect the oldest entry combinationally from storage, with zero latency after push (entry visible the cycle after the push edge).
REQ-023 When empty, out_data, out_zero, out_neg, out_dz SHALL all be driven 0.
REQ-024 Write and read pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-025 Simultaneous push and pop, 0 < count < DEPTH: both pointers advance, count unchanged.
REQ-026 count == DEPTH: in_valid ignored, no write, no pointer change; pop still allowed (in_ready rises next cycle).
REQ-027 count == 0: out_ready ignored; push alone takes effect.
REQ-028 in_op, in_f, in_b SHALL be ignored when no push occurs.
REQ-029 Entries SHALL leave strictly in push order; no entry dropped or duplicated.

Reset
REQ-030 rst_n low SHALL immediately (asynchronously) clear write pointer, read pointer and count to 0.
REQ-031 During and after reset: out_valid = 0, in_ready = 1, out_data/flags = 0.
REQ-032 Storage array is not reset; stale contents SHALL never be observable because of REQ-023.
REQ-033 Reset asserted mid-operation SHALL discard all entries; first push after deassertion lands at index 0.

Verification
REQ-034 Reset, push f=0x0005 op=000 -> next cycle out_valid=1, out_data=0x0005, zero=0, neg=0, dz=0, count=1.
REQ-035 Push op=011 b=0x0000 f=0x1234 -> head out_data=0x0000, zero=1, dz=1, neg=0.
REQ-036 Push 4 results 0x0001..0x0004 with out_ready=0 -> count=4, in_ready=0; 5th push 0x0005 ignored; drain -> 0x0001,0x0002,0x0003,0x0004 in order, count reaches 0, out_valid=0.
REQ-037 Hold count=2, drive push 0x8000 and pop every cycle for 8 cycles -> count stays 2, pointers wrap twice, each popped value matches push order, 0x8000 entries show neg=1.
REQ-038 Push 3 entries, pulse rst_n low between clock edges -> count=0, out_valid=0 immediately; next push 0x00AA read back as first entry.
REQ-039 count=4, assert out_ready and in_valid same cycle -> one pop only, count=3, in_ready=1 next cycle, pushed value not stored.
